// File: rtl/sched_pkg.sv
// Shared types and defaults for the frame scheduler: FSM state encoding,
// watchdog/counter defaults and the busy-state decode.
package sched_pkg;

    localparam int TIMEOUT_DEFAULT = 1023;
    localparam int CNT_W_DEFAULT   = 16;
    localparam int INTERVAL_W      = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        START       = 3'd1,
        WAIT_EXP    = 3'd2,
        WAIT_ADC_HI = 3'd3,
        WAIT_ADC_LO = 3'd4,
        GAP         = 3'd5,
        ERROR       = 3'd6
    } sched_state_t;

    // A frame is in flight in these states; requests arriving here are dropped.
    function automatic logic is_busy(sched_state_t s);
        return (s == START) || (s == WAIT_EXP) || (s == WAIT_ADC_HI) ||
               (s == WAIT_ADC_LO) || (s == GAP);
    endfunction

endpackage

// File: rtl/frame_scheduler_if.sv
// Signal bundle between the frame scheduler, its requester and the exposure
// controller. The slave modport is the scheduler side.
interface frame_scheduler_if
    import sched_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    // Snap and Cont_en are level requests sampled every cycle with no ready
    // back-pressure: a request seen while a frame is in flight is not queued,
    // it is dropped and recorded in the sticky Missed flag until Clear.
    logic                  Snap;
    logic                  Cont_en;
    logic [INTERVAL_W-1:0] Interval;
    logic                  Clear;
    logic                  Expose;
    logic                  ADC;
    logic                  Init;
    logic                  Active;
    logic                  Frame_done;
    logic [CNT_W-1:0]      Frame_cnt;
    logic                  Missed;
    logic                  Err;

    modport slave (
        input  Snap, Cont_en, Interval, Clear, Expose, ADC,
        output Init, Active, Frame_done, Frame_cnt, Missed, Err
    );

    modport master (
        output Snap, Cont_en, Interval, Clear, Expose, ADC,
        input  Init, Active, Frame_done, Frame_cnt, Missed, Err
    );
endinterface

// File: rtl/gap_timer.sv
// Loadable down-counter that times the idle gap between continuous frames.
// expired is high once the count is 1 or less, so a load of 0 or 1 ends at once.
module gap_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expired
);
    logic [W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (en && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q <= W'(1));
endmodule

// File: rtl/frame_scheduler.sv
// Frame capture sequencer: starts frames on request or continuously, follows the
// exposure controller's phases and guards every wait state with a watchdog.
module frame_scheduler
    import sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic              Clk,
    input  logic              Reset,
    frame_scheduler_if.slave  bus,
    output sched_state_t      dbg_state
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    sched_state_t     state_q, state_d;
    logic [WD_W-1:0]  wd_q;
    logic             in_wait;
    logic             wd_timeout;
    logic             frame_end;
    logic             gap_load;
    logic             gap_expired;
    logic             missed_set;

    logic             init_q;
    logic             active_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;
    logic             missed_q;
    logic             err_q;

    assign in_wait    = (state_q == WAIT_EXP) || (state_q == WAIT_ADC_HI) ||
                        (state_q == WAIT_ADC_LO);
    assign wd_timeout = in_wait && (wd_q == WD_W'(TIMEOUT - 1));
    assign missed_set = bus.Snap && is_busy(state_q);

    gap_timer #(.W(INTERVAL_W)) u_gap_timer (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (gap_load),
        .load_val (bus.Interval),
        .en       (state_q == GAP),
        .expired  (gap_expired)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_end = 1'b0;
        gap_load  = 1'b0;
        case (state_q)
            IDLE:        if (bus.Snap || bus.Cont_en) state_d = START;
            START:       state_d = WAIT_EXP;
            WAIT_EXP:    if (bus.Expose) state_d = WAIT_ADC_HI;
            WAIT_ADC_HI: if (bus.ADC) state_d = WAIT_ADC_LO;
            WAIT_ADC_LO: begin
                if (!bus.ADC) begin
                    frame_end = 1'b1;
                    if (bus.Cont_en) begin
                        state_d  = GAP;
                        gap_load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            // Dropping Cont_en beats an expiring gap in the same cycle.
            GAP: begin
                if (!bus.Cont_en)    state_d = IDLE;
                else if (gap_expired) state_d = START;
            end
            ERROR:       if (bus.Clear) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
        // The watchdog overrides a wait condition that lands on the same cycle.
        if (wd_timeout) begin
            state_d   = ERROR;
            frame_end = 1'b0;
            gap_load  = 1'b0;
        end
    end

    // Restarts from zero on every state change, so each wait state is timed alone.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            wd_q <= '0;
        end else if (!in_wait || (state_d != state_q)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            init_q   <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            missed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            init_q   <= (state_q == START);
            active_q <= is_busy(state_q);
            done_q   <= frame_end;
            if (frame_end) cnt_q <= cnt_q + 1'b1;
            // Set events outrank Clear so a coincident event is never lost.
            if (missed_set)     missed_q <= 1'b1;
            else if (bus.Clear) missed_q <= 1'b0;
            if (wd_timeout)     err_q <= 1'b1;
            else if (bus.Clear) err_q <= 1'b0;
        end
    end

    assign bus.Init       = init_q;
    assign bus.Active     = active_q;
    assign bus.Frame_done = done_q;
    assign bus.Frame_cnt  = cnt_q;
    assign bus.Missed     = missed_q;
    assign bus.Err        = err_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench for frame_scheduler: a per-cycle vector table for a single
// frame plus hand-written sequences for continuous mode, watchdog, Missed and wrap.
module tb_frame_scheduler;
  import sched_pkg::*;

  localparam int TB_TIMEOUT = 16;
  localparam int TB_CNT_W   = 4;

  logic clk;
  logic rst_n;
  sched_state_t dbg_state;

  frame_scheduler_if #(.CNT_W(TB_CNT_W)) bus ();

  frame_scheduler #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int init_pulses = 0;
  logic [TB_CNT_W-1:0] exp_cnt;
  logic [TB_CNT_W-1:0] exp_q[$];

  typedef struct {
    logic snap, cont_en, clear, expose, adc;
    logic e_init, e_active, e_done;
    logic [TB_CNT_W-1:0] e_cnt;
    logic e_missed, e_err;
  } vec_t;

  vec_t vecs[14];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past 200000 time units, required completion");
    $fatal(1, "bench timeout");
  end

  // scoreboard: every Frame_done must match the next expected count
  always @(negedge clk) begin
    if (rst_n && bus.Frame_done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL frame_done_unexpected: got pulse with Frame_cnt=%0d, required no pulse", bus.Frame_cnt);
      end else begin
        logic [TB_CNT_W-1:0] e;
        e = exp_q.pop_front();
        if (bus.Frame_cnt !== e) begin
          errors++;
          $display("FAIL sb_frame_cnt: got %0d, required %0d", bus.Frame_cnt, e);
        end
      end
    end
    if (bus.Init) init_pulses++;
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.Snap = 1'b0; bus.Cont_en = 1'b0; bus.Interval = 8'd0;
    bus.Clear = 1'b0; bus.Expose = 1'b0; bus.ADC = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    exp_cnt = '0;
    rst_n = 1'b1;
  endtask

  // Starts with Init just observed (state WAIT_EXP); ends on the Frame_done cycle.
  task automatic frame_body();
    bus.Expose = 1'b1; tick();
    bus.Expose = 1'b0; bus.ADC = 1'b1; tick();
    tick();
    bus.ADC = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back(exp_cnt);
    tick();
    check("frame_done", 32'(bus.Frame_done), 1);
    check("frame_cnt", 32'(bus.Frame_cnt), 32'(exp_cnt));
  endtask

  task automatic single_frame();
    bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0; tick();
    check("snap_init", 32'(bus.Init), 1);
    frame_body();
  endtask

  task automatic wait_init(input int max_cyc, output int waited, output bit seen);
    waited = 0;
    seen = 1'b0;
    while (waited < max_cyc) begin
      if (bus.Init) begin
        seen = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  // Continuous mode: n frames at Interval=4, then Cont_en drops drop_at cycles into the last gap.
  task automatic run_cont(input int n_frames, input int drop_at);
    int waited;
    bit seen;
    int pb;
    do_reset();
    bus.Cont_en = 1'b1;
    bus.Interval = 8'd4;
    for (int f = 0; f < n_frames; f++) begin
      wait_init(20, waited, seen);
      check("cont_init_seen", 32'(seen), 1);
      if (!seen) return;
      if (f > 0) check("gap_init_spacing", waited, 5);
      frame_body();
    end
    repeat (drop_at) tick();
    bus.Cont_en = 1'b0;
    pb = init_pulses;
    repeat (8) tick();
    check("gap_abort_no_init", init_pulses - pb, 0);
    check("gap_abort_active", 32'(bus.Active), 0);
    check("gap_abort_cnt", 32'(bus.Frame_cnt), n_frames);
    check("gap_abort_state", 32'(dbg_state), 32'(IDLE));
  endtask

  function automatic vec_t mk(input logic s, c, cl, e, a, ei, ea, ed,
                              input logic [TB_CNT_W-1:0] ec, input logic em, ee);
    vec_t v;
    v.snap = s; v.cont_en = c; v.clear = cl; v.expose = e; v.adc = a;
    v.e_init = ei; v.e_active = ea; v.e_done = ed; v.e_cnt = ec;
    v.e_missed = em; v.e_err = ee;
    return v;
  endfunction

  initial begin
    int pb;
    //            snap cont clr exp adc | init act done cnt miss err
    vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 4'd0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0,  1, 1, 0, 4'd0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[6]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0,  0, 1, 0, 4'd0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 4'd0, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 1,  0, 1, 0, 4'd0, 0, 0);
    vecs[10] = mk(0, 0, 0, 0, 1,  0, 1, 0, 4'd0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0,  0, 1, 1, 4'd1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 0,  0, 0, 0, 4'd1, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0,  0, 0, 0, 4'd1, 0, 0);

    // reset state
    do_reset();
    check("rst_init", 32'(bus.Init), 0);
    check("rst_active", 32'(bus.Active), 0);
    check("rst_done", 32'(bus.Frame_done), 0);
    check("rst_cnt", 32'(bus.Frame_cnt), 0);
    check("rst_missed", 32'(bus.Missed), 0);
    check("rst_err", 32'(bus.Err), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // single frame, cycle by cycle
    exp_q.push_back(4'd1);
    for (int i = 0; i < 14; i++) begin
      bus.Snap = vecs[i].snap; bus.Cont_en = vecs[i].cont_en; bus.Clear = vecs[i].clear;
      bus.Expose = vecs[i].expose; bus.ADC = vecs[i].adc;
      tick();
      check($sformatf("vec%0d_init", i), 32'(bus.Init), 32'(vecs[i].e_init));
      check($sformatf("vec%0d_active", i), 32'(bus.Active), 32'(vecs[i].e_active));
      check($sformatf("vec%0d_done", i), 32'(bus.Frame_done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_cnt", i), 32'(bus.Frame_cnt), 32'(vecs[i].e_cnt));
      check($sformatf("vec%0d_missed", i), 32'(bus.Missed), 32'(vecs[i].e_missed));
      check($sformatf("vec%0d_err", i), 32'(bus.Err), 32'(vecs[i].e_err));
    end

    // continuous mode; second run drops Cont_en exactly as the gap expires
    run_cont(3, 1);
    run_cont(2, 3);

    // watchdog in WAIT_EXP; Expose arrives on the timeout cycle and must lose
    do_reset();
    bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0; tick();
    check("wd_init", 32'(bus.Init), 1);
    repeat (15) tick();
    check("wd_err_before", 32'(bus.Err), 0);
    check("wd_state_before", 32'(dbg_state), 32'(WAIT_EXP));
    bus.Expose = 1'b1; tick();
    bus.Expose = 1'b0;
    check("wd_err_set", 32'(bus.Err), 1);
    check("wd_state_error", 32'(dbg_state), 32'(ERROR));
    tick();
    check("wd_active_low", 32'(bus.Active), 0);
    pb = init_pulses;
    bus.Snap = 1'b1; bus.Cont_en = 1'b1;
    repeat (3) tick();
    check("err_ignores_req", init_pulses - pb, 0);
    check("err_no_missed", 32'(bus.Missed), 0);
    check("err_stays", 32'(dbg_state), 32'(ERROR));
    bus.Snap = 1'b0; bus.Cont_en = 1'b0; bus.Clear = 1'b1; tick();
    bus.Clear = 1'b0;
    check("clear_err", 32'(bus.Err), 0);
    check("clear_to_idle", 32'(dbg_state), 32'(IDLE));
    tick();
    check("clear_active", 32'(bus.Active), 0);

    // Missed: request while busy, set beats Clear, then Clear+Snap in IDLE
    do_reset();
    pb = init_pulses;
    bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0; tick();
    check("ms_init", 32'(bus.Init), 1);
    bus.Expose = 1'b1; tick();
    bus.Expose = 1'b0;
    check("ms_missed_before", 32'(bus.Missed), 0);
    bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0;
    check("ms_missed_set", 32'(bus.Missed), 1);
    tick(); tick();
    check("ms_no_extra_init", init_pulses - pb, 1);
    bus.Snap = 1'b1; bus.Clear = 1'b1; tick();
    bus.Snap = 1'b0; bus.Clear = 1'b0;
    check("ms_set_beats_clear", 32'(bus.Missed), 1);
    bus.ADC = 1'b1; tick();
    bus.ADC = 1'b0;
    exp_cnt = exp_cnt + 1'b1;
    exp_q.push_back(exp_cnt);
    tick();
    check("ms_frame_done", 32'(bus.Frame_done), 1);
    check("ms_missed_kept", 32'(bus.Missed), 1);
    bus.Snap = 1'b1; bus.Clear = 1'b1; tick();
    bus.Snap = 1'b0; bus.Clear = 1'b0;
    check("ms_clear_idle", 32'(bus.Missed), 0);
    tick();
    check("ms_restart_init", 32'(bus.Init), 1);
    check("ms_init_total", init_pulses - pb, 2);

    // counter wrap at CNT_W=4, then reset mid WAIT_ADC_LO
    do_reset();
    repeat (16) single_frame();
    check("wrap_cnt_zero", 32'(bus.Frame_cnt), 0);
    single_frame();
    bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0; tick();
    bus.Expose = 1'b1; tick();
    bus.Expose = 1'b0; bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0; bus.ADC = 1'b1; tick();
    check("mid_missed", 32'(bus.Missed), 1);
    check("mid_state", 32'(dbg_state), 32'(WAIT_ADC_LO));
    rst_n = 1'b0; tick();
    check("mrst_init", 32'(bus.Init), 0);
    check("mrst_active", 32'(bus.Active), 0);
    check("mrst_done", 32'(bus.Frame_done), 0);
    check("mrst_cnt", 32'(bus.Frame_cnt), 0);
    check("mrst_missed", 32'(bus.Missed), 0);
    check("mrst_err", 32'(bus.Err), 0);
    check("mrst_state", 32'(dbg_state), 32'(IDLE));
    bus.ADC = 1'b0;
    exp_cnt = '0;
    rst_n = 1'b1; bus.Snap = 1'b1; tick();
    bus.Snap = 1'b0;
    check("post_rst_no_init", 32'(bus.Init), 0);
    tick();
    check("post_rst_init", 32'(bus.Init), 1);

    check("frame_q_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 Parameter TIMEOUT, default 1023: maximum cycles spent in any single wait state before an error is declared.
REQ-002 Parameter CNT_W, default 16: width of Frame_cnt.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset (sampled on the Clk rising edge, asserted when 0).
REQ-005 Snap  input  1  single-frame request; sampled every cycle; level, not edge.
REQ-006 Cont_en  input  1  continuous-capture enable.
REQ-007 Interval  input  8  idle gap in cycles between frames in continuous mode; sampled on entry to GAP.
REQ-008 Clear  input  1  clears sticky flags and exits ERROR.
REQ-009 Expose  input  1  exposure-phase indicator from the exposure controller.
REQ-010 ADC  input  1  conversion-phase indicator from the exposure controller.
REQ-011 Init  output  1  one-cycle frame-start pulse to the exposure controller.
REQ-012 Active  output  1  high in every state except IDLE and ERROR.
REQ-013 Frame_done  output  1  one-cycle pulse per completed frame.
REQ-014 Frame_cnt  output  CNT_W  completed-frame count.
REQ-015 Missed  output  1  sticky: a request arrived while busy.
REQ-016 Err  output  1  sticky: watchdog timeout.

Function
REQ-017 States SHALL be IDLE, START, WAIT_EXP, WAIT_ADC_HI, WAIT_ADC_LO, GAP and ERROR; all outputs SHALL be registered.
REQ-018 IDLE: when Snap=1 or Cont_en=1, the next state SHALL be START.
REQ-019 START: Init SHALL be 1 for exactly this one cycle, and the next state SHALL be WAIT_EXP.
- Latency: Snap sampled at edge k gives Init high between edges k+1 and k+2.
REQ-020 Exposure/conversion tracking:
- WAIT_EXP -> WAIT_ADC_HI when Expose=1.
- WAIT_ADC_HI -> WAIT_ADC_LO when ADC=1.
- WAIT_ADC_LO exits when ADC=0.
REQ-021 On the WAIT_ADC_LO exit:
- Frame_done SHALL pulse for one cycle.
- Frame_cnt SHALL increment, wrapping from all-ones to 0.
- Next state SHALL be GAP if Cont_en=1, else IDLE.
REQ-022 GAP entry SHALL load a gap counter with Interval; if Interval=0 the next state SHALL be START directly; otherwise the counter decrements each cycle and the state SHALL move to START in the cycle after the counter reaches 1.
REQ-023 GAP with Cont_en=0 in any cycle SHALL go to IDLE; Cont_en has priority over counter expiry.
REQ-024 Snap=1 while in START, any WAIT state or GAP SHALL set Missed; the request SHALL NOT be queued.
REQ-025 Watchdog:
- Counter SHALL clear on entry to each WAIT state and count every cycle while in it.
- On reaching TIMEOUT it SHALL force ERROR and set Err.
- A wait condition met in the same cycle as the timeout SHALL lose; ERROR wins.
REQ-026 ERROR: Init SHALL stay 0 and Snap/Cont_en SHALL be ignored; Clear=1 SHALL go to IDLE.
REQ-027 Clear=1 SHALL zero Missed and Err in any state; a set event in the same cycle as Clear SHALL win (flag reads 1).
REQ-028 Frame_cnt SHALL NOT be altered by Clear.

Reset
REQ-029 With Reset=0 at a Clk edge the block SHALL enter IDLE with Init, Active, Frame_done, Missed and Err at 0, Frame_cnt at 0 and both internal counters at 0, regardless of current state, including mid-frame.
REQ-030 No Init pulse SHALL be issued in the first cycle after Reset deasserts.

Structure
REQ-031 The state enum and the TIMEOUT default SHALL live in a shared package sched_pkg.
REQ-032 The Interval down-counter SHALL be a sub-module gap_timer (load, enable, expiry flag); the watchdog stays inline.

Verification
REQ-033 Snap=1 for one cycle, Expose high 5 cycles, then ADC high 3 cycles -> one Init pulse, one Frame_done, Frame_cnt=1, Active returns to 0.
REQ-034 Cont_en=1 with Interval=4 for three frames -> three Init pulses, each exactly 5 cycles after the previous Frame_done; Cont_en=0 during the second GAP -> IDLE with Frame_cnt=2.
REQ-035 TIMEOUT=16 with Expose held 0 after Init -> ERROR after 16 cycles in WAIT_EXP, Err=1; Clear=1 -> IDLE and Err=0.
REQ-036 Snap pulsed during WAIT_ADC_HI -> Missed=1, no extra Init; Clear and Snap together in IDLE -> Missed=0 and the frame starts.
REQ-037 Frame_cnt preset near wrap (CNT_W=4, 15 frames completed) plus one more frame -> Frame_cnt=0; Reset=0 mid-WAIT_ADC_LO -> all outputs 0 the next cycle.
